// File: rtl/btb_pkg.sv
// btb_pkg: types and constants shared by the BTB update controller,
// the BTB array and the branch units.
//   PC_W        - PC / target width
//   IDX_W       - BTB index width
//   BTB_ENTRIES - number of BTB entries (2**IDX_W)
//   btb_upd_t   - one BTB update {idx, target, vbit}
//   ctrl_state_e- update controller FSM states
package btb_pkg;

  localparam int PC_W        = 16;
  localparam int IDX_W       = 4;
  localparam int BTB_ENTRIES = 2 ** IDX_W;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  target;
    logic             vbit;
  } btb_upd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO holding pending BTB updates.
//   clk, rst      - clock, synchronous active-high reset
//   push, din     - enqueue din (ignored when full unless popping too)
//   pop, dout     - dequeue; dout shows the head entry
//   clear         - drop all entries (wins over push/pop)
//   full, empty   - status
//   count         - number of entries held
module btb_upd_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       clear,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !clear;
    // a full FIFO can still take a push when the head leaves in the same cycle
    do_push  = push && (!full || do_pop) && !clear;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: arbitrates resolved-branch updates from two branch units,
// queues them, and writes them to the BTB one per cycle; also walks the
// whole BTB clearing valid bits on a flush request.
//   clk, rst                  - clock, synchronous active-high reset
//   reqN_valid/pc/target/taken- resolved branch from unit N
//   reqN_ready                - request N accepted this cycle
//   flush_req                 - invalidate the whole BTB
//   flush_busy, flush_done    - walk in progress / one-cycle completion pulse
//   btb_we/idx/target/vbit    - registered BTB write port
module btb_update_ctrl #(
  parameter int PC_W   = btb_pkg::PC_W,
  parameter int IDX_W  = btb_pkg::IDX_W,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [PC_W-1:0]  req0_pc,
  input  logic [PC_W-1:0]  req0_target,
  input  logic             req0_taken,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [PC_W-1:0]  req1_pc,
  input  logic [PC_W-1:0]  req1_target,
  input  logic             req1_taken,
  output logic             req1_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_idx,
  output logic [PC_W-1:0]  btb_target,
  output logic             btb_vbit
);
  import btb_pkg::*;

  localparam int ENT_W   = IDX_W + PC_W + 1;
  localparam int CNT_W   = IDX_W + 1;
  localparam int ENTRIES = 2 ** IDX_W;

  ctrl_state_e       state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              btb_we_q, btb_we_d;
  logic [IDX_W-1:0]  btb_idx_q, btb_idx_d;
  logic [PC_W-1:0]   btb_target_q, btb_target_d;
  logic              btb_vbit_q, btb_vbit_d;
  logic              flush_done_q, flush_done_d;

  logic              accept_ok, q_push, q_pop, q_clear, q_full, q_empty;
  logic [ENT_W-1:0]  q_din, q_dout;
  logic [$clog2(QDEPTH):0] q_count;

  btb_upd_fifo #(.W(ENT_W), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .clear (q_clear),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign req0_ready = accept_ok && req0_valid && (!req1_valid || !ptr_q);
  assign req1_ready = accept_ok && req1_valid && (!req0_valid ||  ptr_q);
  assign flush_busy = (state_q == ST_FLUSH);
  assign flush_done = flush_done_q;
  assign btb_we     = btb_we_q;
  assign btb_idx    = btb_idx_q;
  assign btb_target = btb_target_q;
  assign btb_vbit   = btb_vbit_q;

  always_comb begin
    accept_ok = !rst && (state_q == ST_IDLE) && !flush_req && !q_full;
    q_push    = req0_ready || req1_ready;
    // not-taken branches store target 0 with vbit 0, invalidating the entry
    if (req1_ready)
      q_din = {req1_pc[IDX_W-1:0], req1_taken ? req1_target : '0, req1_taken};
    else
      q_din = {req0_pc[IDX_W-1:0], req0_taken ? req0_target : '0, req0_taken};
    q_pop   = (state_q == ST_IDLE) && !flush_req && (q_count != '0);
    q_clear = (state_q == ST_IDLE) && flush_req && !q_empty;

    ptr_d        = (req0_valid && req1_valid && q_push) ? !ptr_q : ptr_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    btb_we_d     = 1'b0;
    btb_idx_d    = btb_idx_q;
    btb_target_d = btb_target_q;
    btb_vbit_d   = btb_vbit_q;
    flush_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // counter parked at ENTRIES marks the first idle cycle after a walk
        if (cnt_q == CNT_W'(ENTRIES)) begin
          flush_done_d = 1'b1;
          cnt_d        = '0;
        end
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (q_pop) begin
          btb_we_d = 1'b1;
          {btb_idx_d, btb_target_d, btb_vbit_d} = q_dout;
        end
      end
      ST_FLUSH: begin
        btb_we_d     = 1'b1;
        btb_idx_d    = cnt_q[IDX_W-1:0];
        btb_target_d = '0;
        btb_vbit_d   = 1'b0;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ENTRIES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= '0;
      btb_we_q     <= 1'b0;
      btb_idx_q    <= '0;
      btb_target_q <= '0;
      btb_vbit_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      btb_we_q     <= btb_we_d;
      btb_idx_q    <= btb_idx_d;
      btb_target_q <= btb_target_d;
      btb_vbit_q   <= btb_vbit_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule
